sp_bram_banked: RTL and testbench

//  Single-port, block-RAM-mapped memory of arbitrary width and depth, built from NUM_BANKS banks.

---
 rtl/sp_bram_pkg.sv | 18 +
 rtl/sp_bram_bank.sv | 79 +++++++
 rtl/sp_bram_banked.sv | 131 +++++++++++++
 tb/tb_sp_bram_banked.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_bram_pkg.sv
// Shared types and sizing helpers for the banked single-port block-RAM.
package sp_bram_pkg;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } wmode_e;

    function automatic int num_bytes(input int dw, input int bw);
        return (dw + bw - 1) / bw;
    endfunction

    function automatic int bsel_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 0;
    endfunction

endpackage

// File: rtl/sp_bram_bank.sv
// One block-RAM bank: byte-lane write, write-mode dependent read port and
// the 1-cycle registered BRAM output.
module sp_bram_bank
    import sp_bram_pkg::*;
#(
    parameter int     DATA_WIDTH = 36,
    parameter int     ADDR_WIDTH = 4,
    parameter int     BYTE_WIDTH = 9,
    parameter int     NUM_BYTES  = num_bytes(DATA_WIDTH, BYTE_WIDTH),
    parameter wmode_e WRITE_MODE = READ_FIRST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_BYTES-1:0]  be_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] mask_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] wr_word_s;
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    // Expand lane enables to a per-bit mask; the last lane may be partial.
    always_comb begin
        mask_s = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            mask_s[b] = be_i[b / BYTE_WIDTH];
        end
    end

    assign rd_word_s = mem_q[addr_i];
    assign wr_word_s = (rd_word_s & ~mask_s) | (din_i & mask_s);

    // Storage write; contents are never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_word_s;
        end
    end

    // Read-port selection for the BRAM output register.
    always_comb begin
        dout_d = dout_q;
        if (en_i) begin
            if (!we_i) begin
                dout_d = rd_word_s;
            end else if (WRITE_MODE == WRITE_FIRST) begin
                dout_d = wr_word_s;
            end else if (WRITE_MODE == READ_FIRST) begin
                dout_d = rd_word_s;
            end else begin
                dout_d = dout_q;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // BRAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/sp_bram_banked.sv
// Single-port memory built from NUM_BANKS block-RAM banks, with a valid/bank-select
// pipeline, optional output register and bank output mux.
module sp_bram_banked
    import sp_bram_pkg::*;
#(
    parameter int     DATA_WIDTH      = 1024,
    parameter int     BANK_ADDR_WIDTH = 11,
    parameter int     NUM_BANKS       = 2,
    parameter int     BYTE_WIDTH      = 9,
    parameter wmode_e WRITE_MODE      = READ_FIRST,
    parameter int     OUT_REG         = 1,
    localparam int    BSEL_W          = bsel_w(NUM_BANKS),
    localparam int    ADDR_WIDTH      = BANK_ADDR_WIDTH + BSEL_W,
    localparam int    NUM_BYTES       = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_BYTES-1:0]  req_be,
    input  logic [DATA_WIDTH-1:0] req_din,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_dout
);

    localparam int BSEL_WS = (BSEL_W > 0) ? BSEL_W : 1;

    logic                  accept_s;
    logic                  rsp_gen_s;
    logic [BSEL_WS-1:0]    bsel_s;
    logic                  v1_d;
    logic                  v1_q;
    logic [BSEL_WS-1:0]    bsel_d;
    logic [BSEL_WS-1:0]    bsel_q;
    logic [DATA_WIDTH-1:0] bank_dout_s [NUM_BANKS];
    logic [DATA_WIDTH-1:0] mux_dout_s;

    assign accept_s  = req_valid & ~rst;
    assign rsp_gen_s = accept_s & (~req_we | (WRITE_MODE != NO_CHANGE));

    if (NUM_BANKS > 1) begin : g_bsel
        assign bsel_s = req_addr[ADDR_WIDTH-1 -: BSEL_WS];
    end else begin : g_nobsel
        assign bsel_s = '0;
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic hit_s;
        assign hit_s = accept_s & (bsel_s == BSEL_WS'(k));

        sp_bram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (BANK_ADDR_WIDTH),
            .BYTE_WIDTH (BYTE_WIDTH),
            .NUM_BYTES  (NUM_BYTES),
            .WRITE_MODE (WRITE_MODE)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .en_i   (hit_s),
            .we_i   (hit_s & req_we),
            .addr_i (req_addr[BANK_ADDR_WIDTH-1:0]),
            .be_i   (req_be),
            .din_i  (req_din),
            .dout_o (bank_dout_s[k])
        );
    end

    // Bank select only advances with a response so the mux output holds otherwise.
    always_comb begin
        v1_d = rsp_gen_s;
        if (rsp_gen_s) begin
            bsel_d = bsel_s;
        end else begin
            bsel_d = bsel_q;
        end
    end

    // First pipeline stage, aligned with the BRAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            bsel_q <= '0;
        end else begin
            v1_q   <= v1_d;
            bsel_q <= bsel_d;
        end
    end

    if (NUM_BANKS > 1) begin : g_mux
        assign mux_dout_s = bank_dout_s[bsel_q];
    end else begin : g_nomux
        assign mux_dout_s = bank_dout_s[0];
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                  v2_d;
        logic                  v2_q;
        logic [DATA_WIDTH-1:0] dout_d;
        logic [DATA_WIDTH-1:0] dout_q;

        // Output stage captures only valid responses.
        always_comb begin
            v2_d = v1_q;
            if (v1_q) begin
                dout_d = mux_dout_s;
            end else begin
                dout_d = dout_q;
            end
        end

        // Output register.
        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q   <= 1'b0;
                dout_q <= '0;
            end else begin
                v2_q   <= v2_d;
                dout_q <= dout_d;
            end
        end

        assign rsp_valid = v2_q;
        assign rsp_dout  = dout_q;
    end else begin : g_noreg
        assign rsp_valid = v1_q;
        assign rsp_dout  = mux_dout_s;
    end

endmodule

// File: tb/tb_sp_bram_banked.sv
// Directed bench: four 36-bit instances share one request bus (three write modes with
// OUT_REG=1, READ_FIRST with OUT_REG=0), plus a single-bank 8-bit instance.
module tb_sp_bram_banked;
    import sp_bram_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [3:0]  req_be;
    logic [35:0] req_din;
    logic        rf_valid, wf_valid, nc_valid, r0_valid;
    logic [35:0] rf_dout, wf_dout, nc_dout, r0_dout;

    logic        b_valid;
    logic        b_we;
    logic [3:0]  b_addr;
    logic [0:0]  b_be;
    logic [7:0]  b_din;
    logic        b_rsp_valid;
    logic [7:0]  b_rsp_dout;

    int checks = 0;
    int errors = 0;

    sp_bram_banked #(.DATA_WIDTH(36), .BANK_ADDR_WIDTH(4), .NUM_BANKS(4), .BYTE_WIDTH(9),
                     .WRITE_MODE(READ_FIRST), .OUT_REG(1)) u_rf (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_din(req_din), .rsp_valid(rf_valid), .rsp_dout(rf_dout));

    sp_bram_banked #(.DATA_WIDTH(36), .BANK_ADDR_WIDTH(4), .NUM_BANKS(4), .BYTE_WIDTH(9),
                     .WRITE_MODE(WRITE_FIRST), .OUT_REG(1)) u_wf (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_din(req_din), .rsp_valid(wf_valid), .rsp_dout(wf_dout));

    sp_bram_banked #(.DATA_WIDTH(36), .BANK_ADDR_WIDTH(4), .NUM_BANKS(4), .BYTE_WIDTH(9),
                     .WRITE_MODE(NO_CHANGE), .OUT_REG(1)) u_nc (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_din(req_din), .rsp_valid(nc_valid), .rsp_dout(nc_dout));

    sp_bram_banked #(.DATA_WIDTH(36), .BANK_ADDR_WIDTH(4), .NUM_BANKS(4), .BYTE_WIDTH(9),
                     .WRITE_MODE(READ_FIRST), .OUT_REG(0)) u_r0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_din(req_din), .rsp_valid(r0_valid), .rsp_dout(r0_dout));

    sp_bram_banked #(.DATA_WIDTH(8), .BANK_ADDR_WIDTH(4), .NUM_BANKS(1), .BYTE_WIDTH(9),
                     .WRITE_MODE(READ_FIRST), .OUT_REG(1)) u_b1 (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
        .req_be(b_be), .req_din(b_din), .rsp_valid(b_rsp_valid), .rsp_dout(b_rsp_dout));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [3:0]  be;
        logic [35:0] din;
        logic [35:0] exp_rf;
        logic [35:0] exp_wf;
        logic        exp_nc_v;
        logic [35:0] exp_nc;
    } vec_t;

    vec_t vecs [18];

    function automatic logic [35:0] pat(input int a);
        logic [5:0] s;
        s = 6'(a);
        return {s, 24'h000000, s};
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [5:0] a,
                         input logic [3:0] be, input logic [35:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_din   = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'h00, 4'h0, 36'h000000000);
    endtask

    task automatic prefill();
        for (int a = 0; a < 64; a++) begin
            drive(1'b1, 1'b1, 6'(a), 4'hF, pat(a));
            step();
        end
        idle();
        step();
        step();
    endtask

    task automatic b_req(input logic v, input logic we, input logic [3:0] a,
                         input logic be, input logic [7:0] d);
        b_valid = v;
        b_we    = we;
        b_addr  = a;
        b_be    = be;
        b_din   = d;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 6'h00, 4'hF, 36'h123456789, 36'h000000000, 36'h123456789, 1'b0, 36'h000000000};
        vecs[1]  = '{1'b1, 6'h10, 4'hF, 36'h123456789, 36'h400000010, 36'h123456789, 1'b0, 36'h000000000};
        vecs[2]  = '{1'b1, 6'h20, 4'hF, 36'h123456789, 36'h800000020, 36'h123456789, 1'b0, 36'h000000000};
        vecs[3]  = '{1'b1, 6'h30, 4'hF, 36'h123456789, 36'hC00000030, 36'h123456789, 1'b0, 36'h000000000};
        vecs[4]  = '{1'b0, 6'h00, 4'h0, 36'h000000000, 36'h123456789, 36'h123456789, 1'b1, 36'h123456789};
        vecs[5]  = '{1'b0, 6'h10, 4'hF, 36'h000000000, 36'h123456789, 36'h123456789, 1'b1, 36'h123456789};
        vecs[6]  = '{1'b0, 6'h20, 4'h0, 36'h000000000, 36'h123456789, 36'h123456789, 1'b1, 36'h123456789};
        vecs[7]  = '{1'b0, 6'h30, 4'h0, 36'h000000000, 36'h123456789, 36'h123456789, 1'b1, 36'h123456789};
        vecs[8]  = '{1'b0, 6'h01, 4'h0, 36'h000000000, 36'h040000001, 36'h040000001, 1'b1, 36'h040000001};
        vecs[9]  = '{1'b0, 6'h31, 4'h0, 36'h000000000, 36'hC40000031, 36'hC40000031, 1'b1, 36'hC40000031};
        vecs[10] = '{1'b1, 6'h05, 4'hF, 36'hFFFFFFFFF, 36'h140000005, 36'hFFFFFFFFF, 1'b0, 36'hC40000031};
        vecs[11] = '{1'b1, 6'h05, 4'h5, 36'h000000000, 36'hFFFFFFFFF, 36'hFF803FE00, 1'b0, 36'hC40000031};
        vecs[12] = '{1'b0, 6'h05, 4'h0, 36'h000000000, 36'hFF803FE00, 36'hFF803FE00, 1'b1, 36'hFF803FE00};
        vecs[13] = '{1'b1, 6'h07, 4'hF, 36'hAAAAAAAAA, 36'h1C0000007, 36'hAAAAAAAAA, 1'b0, 36'hFF803FE00};
        vecs[14] = '{1'b1, 6'h07, 4'hF, 36'h555555555, 36'hAAAAAAAAA, 36'h555555555, 1'b0, 36'hFF803FE00};
        vecs[15] = '{1'b1, 6'h05, 4'h0, 36'h000000123, 36'hFF803FE00, 36'hFF803FE00, 1'b0, 36'hFF803FE00};
        vecs[16] = '{1'b0, 6'h05, 4'h0, 36'h000000000, 36'hFF803FE00, 36'hFF803FE00, 1'b1, 36'hFF803FE00};
        vecs[17] = '{1'b0, 6'h07, 4'h0, 36'h000000000, 36'h555555555, 36'h555555555, 1'b1, 36'h555555555};

        rst = 1'b1;
        idle();
        b_req(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
        step();
        step();
        step();
        chk("reset rf_valid", 36'(rf_valid), 36'h0);
        chk("reset rf_dout", rf_dout, 36'h0);
        chk("reset nc_dout", nc_dout, 36'h0);
        chk("reset r0_valid", 36'(r0_valid), 36'h0);
        chk("reset r0_dout", r0_dout, 36'h0);
        chk("reset b_dout", 36'(b_rsp_dout), 36'h0);
        rst = 1'b0;

        prefill();

        // Table: each request followed by one idle cycle.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].din);
            step();
            idle();
            chk($sformatf("v%0d r0_valid N+1", i), 36'(r0_valid), 36'h1);
            chk($sformatf("v%0d r0_dout N+1", i), r0_dout, vecs[i].exp_rf);
            chk($sformatf("v%0d rf_valid N+1", i), 36'(rf_valid), 36'h0);
            step();
            chk($sformatf("v%0d rf_valid", i), 36'(rf_valid), 36'h1);
            chk($sformatf("v%0d rf_dout", i), rf_dout, vecs[i].exp_rf);
            chk($sformatf("v%0d wf_valid", i), 36'(wf_valid), 36'h1);
            chk($sformatf("v%0d wf_dout", i), wf_dout, vecs[i].exp_wf);
            chk($sformatf("v%0d nc_valid", i), 36'(nc_valid), 36'(vecs[i].exp_nc_v));
            chk($sformatf("v%0d nc_dout", i), nc_dout, vecs[i].exp_nc);
            chk($sformatf("v%0d r0 hold valid", i), 36'(r0_valid), 36'h0);
            chk($sformatf("v%0d r0 hold dout", i), r0_dout, vecs[i].exp_rf);
        end

        // Streaming reads: r0 answers at N+1, rf at N+2.
        prefill();
        for (int c = 0; c < 66; c++) begin
            if (c < 64) drive(1'b1, 1'b0, 6'(c), 4'h0, 36'h000000000);
            else idle();
            step();
            if (c < 64) begin
                chk($sformatf("stream r0_valid c%0d", c), 36'(r0_valid), 36'h1);
                chk($sformatf("stream r0_dout c%0d", c), r0_dout, pat(c));
            end else begin
                chk($sformatf("stream r0_valid c%0d", c), 36'(r0_valid), 36'h0);
            end
            if (c >= 1 && c <= 64) begin
                chk($sformatf("stream rf_valid c%0d", c), 36'(rf_valid), 36'h1);
                chk($sformatf("stream rf_dout c%0d", c), rf_dout, pat(c - 1));
            end else begin
                chk($sformatf("stream rf_valid c%0d", c), 36'(rf_valid), 36'h0);
            end
        end

        // Write then immediate read of the same address.
        drive(1'b1, 1'b1, 6'h09, 4'hF, 36'h0DEADBEEF);
        step();
        drive(1'b1, 1'b0, 6'h09, 4'h0, 36'h000000000);
        step();
        idle();
        chk("raw r0_dout", r0_dout, 36'h0DEADBEEF);
        chk("raw rf_dout wr", rf_dout, 36'h240000009);
        chk("raw wf_dout wr", wf_dout, 36'h0DEADBEEF);
        chk("raw nc_valid wr", 36'(nc_valid), 36'h0);
        step();
        chk("raw rf_valid rd", 36'(rf_valid), 36'h1);
        chk("raw rf_dout rd", rf_dout, 36'h0DEADBEEF);
        chk("raw nc_valid rd", 36'(nc_valid), 36'h1);
        chk("raw nc_dout rd", nc_dout, 36'h0DEADBEEF);
        step();

        // Reset drops in-flight reads and blocks the concurrent write.
        drive(1'b1, 1'b0, 6'h01, 4'h0, 36'h000000000);
        step();
        chk("rst r0 pre valid", 36'(r0_valid), 36'h1);
        chk("rst r0 pre dout", r0_dout, 36'h040000001);
        rst = 1'b1;
        drive(1'b1, 1'b1, 6'h02, 4'hF, 36'h999999999);
        step();
        rst = 1'b0;
        idle();
        chk("rst rf_valid N+2", 36'(rf_valid), 36'h0);
        chk("rst rf_dout N+2", rf_dout, 36'h0);
        chk("rst r0_valid N+2", 36'(r0_valid), 36'h0);
        chk("rst r0_dout N+2", r0_dout, 36'h0);
        step();
        chk("rst rf_valid N+3", 36'(rf_valid), 36'h0);
        chk("rst rf_dout N+3", rf_dout, 36'h0);
        drive(1'b1, 1'b0, 6'h02, 4'h0, 36'h000000000);
        step();
        idle();
        step();
        chk("rst write blocked valid", 36'(rf_valid), 36'h1);
        chk("rst write blocked dout", rf_dout, 36'h080000002);

        // Single bank, single partial lane.
        b_req(1'b1, 1'b1, 4'h3, 1'b1, 8'hA5);
        step();
        b_req(1'b1, 1'b1, 4'h4, 1'b1, 8'h3C);
        step();
        b_req(1'b1, 1'b1, 4'h3, 1'b0, 8'h00);
        step();
        b_req(1'b1, 1'b0, 4'h3, 1'b0, 8'h00);
        step();
        chk("b1 be0 write rsp", 36'(b_rsp_dout), 36'hA5);
        b_req(1'b1, 1'b0, 4'h4, 1'b0, 8'h00);
        step();
        b_req(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
        chk("b1 read A5 valid", 36'(b_rsp_valid), 36'h1);
        chk("b1 read A5 dout", 36'(b_rsp_dout), 36'hA5);
        step();
        chk("b1 read 3C dout", 36'(b_rsp_dout), 36'h3C);
        step();
        chk("b1 idle valid", 36'(b_rsp_valid), 36'h0);
        chk("b1 idle hold", 36'(b_rsp_dout), 36'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
